pipe_hazard_ctrl: RTL and testbench

Hazard and pipeline-sequencing controller for the five-stage (IF/D/X/M/WB) successor of the single-cycle core. It tracks the destination and source registers of the instructions in X, M and WB, and drives the IF stall input (tied to DISABLE in the single-cycle top). It also generates the bubble and flush controls, the X-stage operand forwarding selects, and a saturating hazard-stall counter. Register-address width and forwarding mode are parameters, so the same block serves a forwarding and a non-forwarding build.

---
 rtl/pipe_hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - hazard detection, bubble/flush/stall and X-stage forwarding for the 5-stage core
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int FORWARD    = 1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic [REG_ADDR_W-1:0] id_dst,
  input  logic                  ex_redirect,
  output logic                  stall,
  output logic                  bubble,
  output logic                  flush,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // X record keeps sources for forwarding; M/WB only need what identifies a writer.
  // mem_read matters only while the producer sits in X, so later stages drop it.
  logic                  x_valid, x_reg_write, x_mem_read, x_uses_rs, x_uses_rt;
  logic [REG_ADDR_W-1:0] x_dst, x_rs, x_rt;
  logic                  m_valid, m_reg_write;
  logic [REG_ADDR_W-1:0] m_dst;
  logic                  wb_valid, wb_reg_write;
  logic [REG_ADDR_W-1:0] wb_dst;

  logic x_writer, m_writer, wb_writer;
  logic rs_hit_x, rt_hit_x, rs_hit_m, rt_hit_m;
  logic hazard;

  assign x_writer  = x_valid  & x_reg_write  & (x_dst  != '0);
  assign m_writer  = m_valid  & m_reg_write  & (m_dst  != '0);
  assign wb_writer = wb_valid & wb_reg_write & (wb_dst != '0);

  assign rs_hit_x = id_uses_rs & (id_rs == x_dst);
  assign rt_hit_x = id_uses_rt & (id_rt == x_dst);
  assign rs_hit_m = id_uses_rs & (id_rs == m_dst);
  assign rt_hit_m = id_uses_rt & (id_rt == m_dst);

  // Forward select for one X operand: youngest producer (M) wins over WB
  function automatic logic [1:0] fwd_sel(
    input logic                  use_src,
    input logic [REG_ADDR_W-1:0] src,
    input logic                  m_wr,
    input logic [REG_ADDR_W-1:0] m_d,
    input logic                  wb_wr,
    input logic [REG_ADDR_W-1:0] wb_d
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (use_src) begin
      if (m_wr && (m_d == src))
        sel = 2'b01;
      else if (wb_wr && (wb_d == src))
        sel = 2'b10;
    end
    return sel;
  endfunction

  // RAW detection: only load-use with forwarding, any X/M producer without it
  always_comb begin
    hazard = 1'b0;
    if (FORWARD != 0)
      hazard = id_valid & x_writer & x_mem_read & (rs_hit_x | rt_hit_x);
    else
      hazard = id_valid & ((x_writer & (rs_hit_x | rt_hit_x)) |
                           (m_writer & (rs_hit_m | rt_hit_m)));
  end

  // Pipeline controls; redirect beats hazard, freeze holds everything
  always_comb begin
    stall  = 1'b0;
    bubble = 1'b0;
    flush  = 1'b0;
    if (rst) begin
      if (freeze) begin
        stall = 1'b1;
      end else begin
        stall  = hazard & ~ex_redirect;
        bubble = hazard & ~ex_redirect;
        flush  = ex_redirect;
      end
    end
  end

  // Operand selects for the instruction currently in X
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (rst && (FORWARD != 0) && x_valid) begin
      fwd_a = fwd_sel(x_uses_rs, x_rs, m_writer, m_dst, wb_writer, wb_dst);
      fwd_b = fwd_sel(x_uses_rt, x_rt, m_writer, m_dst, wb_writer, wb_dst);
    end
  end

  // Stage records advance and hazard stalls are counted when not frozen
  always_ff @(posedge clk) begin
    if (!rst) begin
      x_valid      <= 1'b0;
      x_reg_write  <= 1'b0;
      x_mem_read   <= 1'b0;
      x_uses_rs    <= 1'b0;
      x_uses_rt    <= 1'b0;
      x_dst        <= '0;
      x_rs         <= '0;
      x_rt         <= '0;
      m_valid      <= 1'b0;
      m_reg_write  <= 1'b0;
      m_dst        <= '0;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_dst       <= '0;
      stall_cnt    <= '0;
    end else if (!freeze) begin
      wb_valid     <= m_valid;
      wb_reg_write <= m_reg_write;
      wb_dst       <= m_dst;
      m_valid      <= x_valid;
      m_reg_write  <= x_reg_write;
      m_dst        <= x_dst;
      x_valid      <= id_valid & ~bubble & ~flush;
      x_reg_write  <= id_reg_write;
      x_mem_read   <= id_mem_read;
      x_uses_rs    <= id_uses_rs;
      x_uses_rt    <= id_uses_rt;
      x_dst        <= id_dst;
      x_rs         <= id_rs;
      x_rt         <= id_rt;
      if (stall && (stall_cnt != CNT_MAX))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - randomized and directed bench for pipe_hazard_ctrl against an instruction-level model
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst, freeze, id_valid, id_uses_rs, id_uses_rt;
  logic       id_reg_write, id_mem_read, ex_redirect;
  logic [4:0] id_rs, id_rt, id_dst;

  logic        stall_f, bubble_f, flush_f;
  logic [1:0]  fwd_a_f, fwd_b_f;
  logic [15:0] cnt_f;
  logic        stall_n, bubble_n, flush_n;
  logic [1:0]  fwd_a_n, fwd_b_n;
  logic [15:0] cnt_n;
  logic        stall_s, bubble_s, flush_s;
  logic [1:0]  fwd_a_s, fwd_b_s;
  logic [1:0]  cnt_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_ADDR_W(5), .FORWARD(1), .CNT_W(16)) u_fwd (
    .clk(clk), .rst(rst), .freeze(freeze), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_dst(id_dst),
    .ex_redirect(ex_redirect), .stall(stall_f), .bubble(bubble_f), .flush(flush_f),
    .fwd_a(fwd_a_f), .fwd_b(fwd_b_f), .stall_cnt(cnt_f));

  pipe_hazard_ctrl #(.REG_ADDR_W(5), .FORWARD(0), .CNT_W(16)) u_nofwd (
    .clk(clk), .rst(rst), .freeze(freeze), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_dst(id_dst),
    .ex_redirect(ex_redirect), .stall(stall_n), .bubble(bubble_n), .flush(flush_n),
    .fwd_a(fwd_a_n), .fwd_b(fwd_b_n), .stall_cnt(cnt_n));

  pipe_hazard_ctrl #(.REG_ADDR_W(5), .FORWARD(1), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .freeze(freeze), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_dst(id_dst),
    .ex_redirect(ex_redirect), .stall(stall_s), .bubble(bubble_s), .flush(flush_s),
    .fwd_a(fwd_a_s), .fwd_b(fwd_b_s), .stall_cnt(cnt_s));

  // Instruction-level model: pipe[mode][age], age 0 = X, 1 = M, 2 = WB
  typedef struct {
    bit v, rw, mr, urs, urt;
    int dst, rs, rt;
  } rec_t;
  rec_t pipe [2][3];
  int   cnt  [2];

  task automatic chk_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit writer(input rec_t r);
    return r.v && r.rw && (r.dst != 0);
  endfunction

  function automatic bit d_reads(input int d);
    return (id_uses_rs && (int'(id_rs) == d)) || (id_uses_rt && (int'(id_rt) == d));
  endfunction

  // Forwarding: only a load in X needs a stall; without it any producer closer than WB
  function automatic bit mdl_haz(input int m);
    int depth;
    depth = (m == 1) ? 1 : 2;
    if (!id_valid) return 1'b0;
    for (int s = 0; s < depth; s++)
      if (writer(pipe[m][s]) && d_reads(pipe[m][s].dst) && (m == 0 || pipe[m][s].mr))
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic int mdl_fwd(input int m, input bit opb);
    rec_t x;
    int   src;
    bit   u;
    x   = pipe[m][0];
    src = opb ? x.rt : x.rs;
    u   = opb ? x.urt : x.urs;
    if (m == 0 || !rst || !x.v || !u) return 0;
    for (int s = 1; s < 3; s++)
      if (writer(pipe[m][s]) && pipe[m][s].dst == src) return s;
    return 0;
  endfunction

  function automatic int exp_stall(input int m);
    if (!rst) return 0;
    if (freeze) return 1;
    return int'(mdl_haz(m) && !ex_redirect);
  endfunction

  function automatic int exp_bubble(input int m);
    if (!rst || freeze) return 0;
    return int'(mdl_haz(m) && !ex_redirect);
  endfunction

  task automatic settle();
    int fl;
    #3;
    fl = int'(rst && !freeze && ex_redirect);
    chk_eq("f_stall",  int'(stall_f),  exp_stall(1));
    chk_eq("f_bubble", int'(bubble_f), exp_bubble(1));
    chk_eq("f_flush",  int'(flush_f),  fl);
    chk_eq("f_fwd_a",  int'(fwd_a_f),  mdl_fwd(1, 1'b0));
    chk_eq("f_fwd_b",  int'(fwd_b_f),  mdl_fwd(1, 1'b1));
    chk_eq("f_cnt",    int'(cnt_f),    cnt[1] > 65535 ? 65535 : cnt[1]);
    chk_eq("n_stall",  int'(stall_n),  exp_stall(0));
    chk_eq("n_bubble", int'(bubble_n), exp_bubble(0));
    chk_eq("n_flush",  int'(flush_n),  fl);
    chk_eq("n_fwd_a",  int'(fwd_a_n),  0);
    chk_eq("n_fwd_b",  int'(fwd_b_n),  0);
    chk_eq("n_cnt",    int'(cnt_n),    cnt[0] > 65535 ? 65535 : cnt[0]);
    chk_eq("s_stall",  int'(stall_s),  exp_stall(1));
    chk_eq("s_fwd_a",  int'(fwd_a_s),  mdl_fwd(1, 1'b0));
    chk_eq("s_cnt",    int'(cnt_s),    cnt[1] > 3 ? 3 : cnt[1]);
  endtask

  task automatic adv();
    bit b;
    for (int m = 0; m < 2; m++) begin
      if (!rst) begin
        for (int s = 0; s < 3; s++) pipe[m][s] = '{default: 0};
        cnt[m] = 0;
      end else if (!freeze) begin
        b = mdl_haz(m) && !ex_redirect;
        if (b) cnt[m]++;
        pipe[m][2]     = pipe[m][1];
        pipe[m][1]     = pipe[m][0];
        pipe[m][0].v   = id_valid && !b && !ex_redirect;
        pipe[m][0].rw  = id_reg_write;
        pipe[m][0].mr  = id_mem_read;
        pipe[m][0].dst = int'(id_dst);
        pipe[m][0].rs  = int'(id_rs);
        pipe[m][0].rt  = int'(id_rt);
        pipe[m][0].urs = id_uses_rs;
        pipe[m][0].urt = id_uses_rt;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    settle();
    adv();
  endtask

  task automatic set_d(input bit v, input int dst, input bit rw, input bit mr,
                       input int rs, input bit urs, input int rt, input bit urt);
    id_valid = v; id_dst = 5'(dst); id_reg_write = rw; id_mem_read = mr;
    id_rs = 5'(rs); id_uses_rs = urs; id_rt = 5'(rt); id_uses_rt = urt;
  endtask

  task automatic nop();
    set_d(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0; freeze = 1'b0; ex_redirect = 1'b0; nop();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; freeze = 1'b0; ex_redirect = 1'b0; nop();
    @(posedge clk);
    #1;
    tick();
    settle();
    chk_eq("rst_cnt", int'(cnt_f), 0);
    adv();
    rst = 1'b1;

    // load-use with forwarding: lw r3 ; add r5,r3,r4
    set_d(1, 3, 1, 1, 1, 1, 0, 0); tick();
    set_d(1, 5, 1, 0, 3, 1, 4, 1); settle();
    chk_eq("lu_stall", int'(stall_f), 1);
    chk_eq("lu_bubble", int'(bubble_f), 1);
    adv();
    settle();
    chk_eq("lu_release", int'(stall_f), 0);
    chk_eq("lu_cnt", int'(cnt_f), 1);
    adv();
    nop(); settle();
    chk_eq("lu_fwd_wb", int'(fwd_a_f), 2);
    adv();

    // ALU back-to-back: add r2 ; sub r6,r2,r2 ; and r8,r2,r0
    do_reset();
    set_d(1, 2, 1, 0, 1, 1, 1, 1); tick();
    set_d(1, 6, 1, 0, 2, 1, 2, 1); settle();
    chk_eq("alu_nostall", int'(stall_f), 0);
    adv();
    set_d(1, 8, 1, 0, 2, 1, 0, 1); settle();
    chk_eq("alu_fwd_a_m", int'(fwd_a_f), 1);
    chk_eq("alu_fwd_b_m", int'(fwd_b_f), 1);
    chk_eq("alu3_nostall", int'(stall_f), 0);
    adv();
    nop(); settle();
    chk_eq("alu3_fwd_a_wb", int'(fwd_a_f), 2);
    chk_eq("alu3_fwd_b_r0", int'(fwd_b_f), 0);
    adv();

    // no forwarding: add r2 ; or r7,r2,r0 held in D until it issues
    do_reset();
    set_d(1, 2, 1, 0, 1, 1, 1, 1); tick();
    set_d(1, 7, 1, 0, 2, 1, 0, 1); settle();
    chk_eq("nf_stall1", int'(stall_n), 1);
    adv();
    settle();
    chk_eq("nf_stall2", int'(stall_n), 1);
    adv();
    settle();
    chk_eq("nf_stall3", int'(stall_n), 0);
    chk_eq("nf_cnt", int'(cnt_n), 2);
    adv();
    nop(); settle();
    chk_eq("nf_fwd", int'(fwd_a_n), 0);
    adv();

    // r0 destination never hazards or forwards
    do_reset();
    set_d(1, 0, 1, 1, 1, 1, 0, 0); tick();
    set_d(1, 5, 1, 0, 0, 1, 0, 1); settle();
    chk_eq("r0_nostall", int'(stall_f), 0);
    adv();
    nop(); settle();
    chk_eq("r0_fwd", int'(fwd_a_f), 0);
    adv();

    // redirect together with a load-use hazard
    do_reset();
    set_d(1, 3, 1, 1, 1, 1, 0, 0); tick();
    set_d(1, 5, 1, 0, 3, 1, 4, 1); ex_redirect = 1'b1; settle();
    chk_eq("rd_flush", int'(flush_f), 1);
    chk_eq("rd_stall", int'(stall_f), 0);
    adv();
    ex_redirect = 1'b0; nop(); settle();
    chk_eq("rd_x_squashed", int'(fwd_a_f), 0);
    chk_eq("rd_cnt", int'(cnt_f), 0);
    adv();

    // freeze for 3 cycles over a load-use hazard
    do_reset();
    set_d(1, 3, 1, 1, 1, 1, 0, 0); tick();
    set_d(1, 5, 1, 0, 3, 1, 4, 1); freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk_eq("fz_stall", int'(stall_f), 1);
      chk_eq("fz_bubble", int'(bubble_f), 0);
      chk_eq("fz_cnt", int'(cnt_f), 0);
      adv();
    end
    freeze = 1'b0; settle();
    chk_eq("fz_rel_bubble", int'(bubble_f), 1);
    adv();
    settle();
    chk_eq("fz_rel_cnt", int'(cnt_f), 1);
    adv();

    // five load-use stalls: 16-bit counter reads 5, 2-bit counter sticks at 3
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_d(1, 3, 1, 1, 1, 1, 0, 0); tick();
      set_d(1, 5, 1, 0, 3, 1, 4, 1); tick();
      tick();
    end
    nop(); settle();
    chk_eq("sat_cnt16", int'(cnt_f), 5);
    chk_eq("sat_cnt2", int'(cnt_s), 3);
    adv();

    // random traffic on a small register set to provoke dense hazards
    for (int i = 0; i < 600; i++) begin
      rst          = ($urandom_range(0, 59) != 0);
      freeze       = ($urandom_range(0, 7) == 0);
      ex_redirect  = ($urandom_range(0, 7) == 0);
      id_valid     = ($urandom_range(0, 5) != 0);
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      id_dst       = 5'($urandom_range(0, 3));
      id_uses_rs   = 1'($urandom_range(0, 1));
      id_uses_rt   = 1'($urandom_range(0, 1));
      id_reg_write = ($urandom_range(0, 3) != 0);
      id_mem_read  = 1'($urandom_range(0, 1));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
